// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit and the decode stage:
// the fetch FSM state encoding, instruction word width and the default
// opcode that halts fetching.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int INSN_W = 16;

    // Opcode in instruction bits [15:12] that stops fetching.
    localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    function automatic logic is_halt_op(input logic [INSN_W-1:0] insn,
                                        input logic [3:0]        op);
        return insn[INSN_W-1 -: 4] == op;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory read bus between the fetch unit and the memory.
//   mem_req  : read request (fetch unit -> memory)
//   mem_addr : word address (fetch unit -> memory)
//   mem_rdy  : mem_data valid this cycle (memory -> fetch unit)
//   mem_data : instruction word (memory -> fetch unit)
// Modports: master = fetch unit side, slave = memory side.
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int ADDR_W = 8
) ();
    import fetch_unit_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rdy;
    logic [INSN_W-1:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdy,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdy,
        output mem_data
    );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// ---------------------------------------------------------------------------
// pc_counter
// Program counter register for the fetch unit.
//   clk         : clock, rising edge
//   res         : synchronous active-high reset, pc -> 0
//   load_i      : load load_addr_i (branch redirect), wins over inc_i
//   load_addr_i : redirect target
//   inc_i       : advance pc by one, wrapping modulo 2^ADDR_W
//   pc_o        : current program counter
// ---------------------------------------------------------------------------
module pc_counter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            // Natural wrap at 2^ADDR_W, no carry out.
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Fetches 16-bit instruction words from a word-addressed memory and hands
// them to the instruction register, one word at a time.
//   clk         : clock, rising edge
//   res         : synchronous active-high reset
//   run         : 1 allows fetching; 0 parks in IDLE at the next issue
//   stall       : instruction register busy, hold the fetched word
//   branch_en   : one-cycle redirect request
//   branch_addr : redirect target
//   mem         : instruction-memory read bus (master side)
//   ir_d        : fetched instruction (registered)
//   ir_en       : instruction register load strobe
//   pc_out      : address of the word on ir_d
//   halted      : halt opcode issued, fetching stopped until reset
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | parked, no request; waits for run
// FETCH | mem_req high at pc; waits for mem_rdy
// ISSUE | word held on ir_d; strobes ir_en once stall drops
// HALT  | halt opcode issued; only res leaves this state
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int         ADDR_W  = 8,
    parameter logic [3:0] HALT_OP = HALT_OP_DEFAULT
) (
    input  logic               clk,
    input  logic               res,
    input  logic               run,
    input  logic               stall,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_addr,
    fetch_unit_if.master       mem,
    output logic [INSN_W-1:0]  ir_d,
    output logic               ir_en,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted
);

    fetch_state_e      state_q,   state_d;
    logic [INSN_W-1:0] ir_word_q, ir_word_d;
    logic [ADDR_W-1:0] pc_out_q,  pc_out_d;
    logic              halted_q,  halted_d;

    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;
    logic              mem_req_c;
    logic              ir_en_c;

    pc_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc_counter (
        .clk         (clk),
        .res         (res),
        .load_i      (pc_load),
        .load_addr_i (branch_addr),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= ST_IDLE;
            ir_word_q <= '0;
            pc_out_q  <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_word_q <= ir_word_d;
            pc_out_q  <= pc_out_d;
            halted_q  <= halted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_word_d = ir_word_q;
        pc_out_d  = pc_out_q;
        halted_d  = halted_q;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        mem_req_c = 1'b0;
        ir_en_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pc_load = branch_en;
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                mem_req_c = 1'b1;
                // A redirect discards whatever the memory returns this cycle
                // and re-requests at the new address next cycle.
                if (branch_en) begin
                    pc_load = 1'b1;
                end else if (mem.mem_rdy) begin
                    ir_word_d = mem.mem_data;
                    pc_out_d  = pc;
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // Branch beats stall: the held word is dropped unissued.
                ir_en_c = !stall && !branch_en;
                if (branch_en) begin
                    pc_load = 1'b1;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    pc_inc = 1'b1;
                    if (is_halt_op(ir_word_q, HALT_OP)) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else if (run) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem.mem_req  = mem_req_c;
    assign mem.mem_addr = pc;
    assign ir_d         = ir_word_q;
    assign ir_en        = ir_en_c;
    assign pc_out       = pc_out_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          res;
    logic          run;
    logic          stall;
    logic          branch_en;
    logic [AW-1:0] branch_addr;
    logic          mem_rdy_tb;
    logic [15:0]   ir_d;
    logic          ir_en;
    logic [AW-1:0] pc_out;
    logic          halted;

    logic [15:0]   mem [256];

    int n_cmp = 0;
    int n_err = 0;

    fetch_unit_if #(.ADDR_W(AW)) mif ();

    assign mif.mem_rdy  = mem_rdy_tb;
    assign mif.mem_data = mem[mif.mem_addr];

    fetch_unit #(
        .ADDR_W  (AW),
        .HALT_OP (4'hF)
    ) dut (
        .clk         (clk),
        .res         (res),
        .run         (run),
        .stall       (stall),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .mem         (mif.master),
        .ir_d        (ir_d),
        .ir_en       (ir_en),
        .pc_out      (pc_out),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Random-phase reference: the unit either holds one fetched word (whose
    // address is exp_pc) or is requesting the word at exp_pc.
    logic          holding;
    logic [AW-1:0] exp_pc;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        end
        mem[0]    = 16'h1234;
        mem[1]    = 16'h2345;
        mem[8'h80] = 16'hF000;

        res = 1'b1; run = 1'b0; stall = 1'b0; branch_en = 1'b0;
        branch_addr = '0; mem_rdy_tb = 1'b0;
        step(); step();

        // Reset state, then idle with run=0 even though memory is ready.
        res = 1'b0; mem_rdy_tb = 1'b1; #1;
        chk("rst_ir_d",    32'(ir_d),   32'h0);
        chk("rst_pc_out",  32'(pc_out), 32'h0);
        chk("rst_halted",  32'(halted), 32'h0);
        chk("rst_mem_req", 32'(mif.mem_req), 32'h0);
        chk("rst_ir_en",   32'(ir_en),  32'h0);
        step(); #1;
        chk("idle_no_run_req", 32'(mif.mem_req), 32'h0);

        // Two back-to-back fetches, zero-wait memory: ir_en in cycles 2 and 4.
        run = 1'b1; #1;
        chk("c0_req", 32'(mif.mem_req), 32'h0);
        step(); #1;
        chk("c1_req",  32'(mif.mem_req),  32'h1);
        chk("c1_addr", 32'(mif.mem_addr), 32'h0);
        chk("c1_ir_en", 32'(ir_en), 32'h0);
        step(); #1;
        chk("c2_ir_en", 32'(ir_en), 32'h1);
        chk("c2_ir_d",  32'(ir_d),  32'h1234);
        chk("c2_pc",    32'(pc_out), 32'h0);
        chk("c2_req",   32'(mif.mem_req), 32'h0);
        step(); #1;
        chk("c3_addr",  32'(mif.mem_addr), 32'h1);
        chk("c3_ir_en", 32'(ir_en), 32'h0);
        step(); #1;
        chk("c4_ir_en", 32'(ir_en), 32'h1);
        chk("c4_ir_d",  32'(ir_d),  32'h2345);
        chk("c4_pc",    32'(pc_out), 32'h1);

        // Stall for three cycles in ISSUE.
        step(); stall = 1'b1; #1;
        chk("st_fetch_addr", 32'(mif.mem_addr), 32'h2);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("st_ir_en", 32'(ir_en), 32'h0);
            chk("st_req",   32'(mif.mem_req), 32'h0);
            chk("st_ir_d",  32'(ir_d), 32'(mem[2]));
            chk("st_pc",    32'(pc_out), 32'h2);
        end
        step(); stall = 1'b0; #1;
        chk("st_release_ir_en", 32'(ir_en), 32'h1);
        chk("st_release_ir_d",  32'(ir_d), 32'(mem[2]));

        // Branch while stalled in ISSUE: held word dropped, redirect to 0x40.
        step(); #1;
        chk("br_fetch_addr", 32'(mif.mem_addr), 32'h3);
        step(); stall = 1'b1; branch_en = 1'b1; branch_addr = 8'h40; #1;
        chk("br_issue_ir_en", 32'(ir_en), 32'h0);
        step(); stall = 1'b0; branch_en = 1'b0; #1;
        chk("br_req",  32'(mif.mem_req),  32'h1);
        chk("br_addr", 32'(mif.mem_addr), 32'h40);
        step(); #1;
        chk("br_ir_en", 32'(ir_en), 32'h1);
        chk("br_ir_d",  32'(ir_d), 32'(mem[8'h40]));
        chk("br_pc",    32'(pc_out), 32'h40);

        // Branch during FETCH with mem_rdy=1: data discarded, refetch at 0xFF.
        step(); branch_en = 1'b1; branch_addr = 8'hFF; #1;
        chk("bf_addr_old", 32'(mif.mem_addr), 32'h41);
        step(); branch_en = 1'b0; #1;
        chk("bf_req",   32'(mif.mem_req),  32'h1);
        chk("bf_addr",  32'(mif.mem_addr), 32'hFF);
        chk("bf_ir_en", 32'(ir_en), 32'h0);
        step(); #1;
        chk("ff_ir_en", 32'(ir_en), 32'h1);
        chk("ff_pc",    32'(pc_out), 32'hFF);
        chk("ff_ir_d",  32'(ir_d), 32'(mem[8'hFF]));

        // pc wraps to 0; run=0 during FETCH does not abort the request.
        step(); run = 1'b0; #1;
        chk("wrap_addr", 32'(mif.mem_addr), 32'h0);
        chk("wrap_req",  32'(mif.mem_req),  32'h1);
        step(); #1;
        chk("run0_ir_en", 32'(ir_en), 32'h1);
        chk("run0_ir_d",  32'(ir_d), 32'h1234);
        step(); #1;
        chk("run0_idle_req",   32'(mif.mem_req), 32'h0);
        chk("run0_idle_ir_en", 32'(ir_en), 32'h0);
        step(); #1;
        chk("run0_idle_req2", 32'(mif.mem_req), 32'h0);
        run = 1'b1; #1;
        step(); #1;
        chk("resume_addr", 32'(mif.mem_addr), 32'h1);
        chk("resume_req",  32'(mif.mem_req),  32'h1);

        // Reset in FETCH with mem_rdy=1: the returned word is not captured.
        res = 1'b1;
        step(); res = 1'b0; run = 1'b0; #1;
        chk("rf_ir_d",  32'(ir_d),  32'h0);
        chk("rf_ir_en", 32'(ir_en), 32'h0);
        chk("rf_req",   32'(mif.mem_req), 32'h0);
        chk("rf_pc",    32'(pc_out), 32'h0);
        step(); #1;
        chk("rf_idle_req", 32'(mif.mem_req), 32'h0);

        // Branch from IDLE with run=1 to the halt word at 0x80.
        run = 1'b1; branch_en = 1'b1; branch_addr = 8'h80; #1;
        step(); branch_en = 1'b0; #1;
        chk("h_addr", 32'(mif.mem_addr), 32'h80);
        chk("h_req",  32'(mif.mem_req),  32'h1);
        step(); #1;
        chk("h_ir_en",  32'(ir_en), 32'h1);
        chk("h_ir_d",   32'(ir_d), 32'hF000);
        chk("h_pre",    32'(halted), 32'h0);
        step(); branch_en = 1'b1; branch_addr = 8'h10; #1;
        chk("h_halted", 32'(halted), 32'h1);
        chk("h_req0",   32'(mif.mem_req), 32'h0);
        chk("h_ir_en0", 32'(ir_en), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(); branch_en = 1'b0; #1;
            chk("h_stay_halted", 32'(halted), 32'h1);
            chk("h_stay_req",    32'(mif.mem_req), 32'h0);
            chk("h_stay_ir_en",  32'(ir_en), 32'h0);
            chk("h_stay_pc",     32'(pc_out), 32'h80);
        end
        res = 1'b1;
        step(); res = 1'b0; #1;
        chk("hr_halted", 32'(halted), 32'h0);
        chk("hr_req",    32'(mif.mem_req), 32'h0);
        chk("hr_pc",     32'(pc_out), 32'h0);
        step(); #1;
        chk("hr_addr", 32'(mif.mem_addr), 32'h0);
        chk("hr_req1", 32'(mif.mem_req),  32'h1);

        // Randomized phase with run=1 and no halt words in memory.
        mem[8'h80] = 16'h0ABC;
        holding = 1'b0;
        exp_pc  = '0;
        for (int n = 0; n < 3000; n++) begin
            stall       = ($urandom_range(0, 2) == 0);
            mem_rdy_tb  = ($urandom_range(0, 1) == 1);
            branch_en   = ($urandom_range(0, 11) == 0);
            branch_addr = 8'($urandom);
            #1;
            chk("rnd_ir_en",  32'(ir_en), 32'(holding && !stall && !branch_en));
            chk("rnd_req",    32'(mif.mem_req), 32'(!holding));
            chk("rnd_halted", 32'(halted), 32'h0);
            if (!holding) begin
                chk("rnd_addr", 32'(mif.mem_addr), 32'(exp_pc));
            end
            if (holding) begin
                chk("rnd_pc_out", 32'(pc_out), 32'(exp_pc));
                chk("rnd_ir_d",   32'(ir_d), 32'(mem[exp_pc]));
            end
            if (branch_en) begin
                exp_pc  = branch_addr;
                holding = 1'b0;
            end else if (holding) begin
                if (!stall) begin
                    holding = 1'b0;
                    exp_pc  = exp_pc + 8'd1;
                end
            end else if (mem_rdy_tb) begin
                holding = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8: program-counter and memory-address width.
REQ-002 Parameter HALT_OP, default 4'hF: opcode in instruction bits [15:12] that stops fetching.
REQ-003 clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 res  in  1  reset, synchronous, active-high.
REQ-005 run  in  1  level; 1 allows fetching, 0 parks the unit in IDLE at the next issue boundary.
REQ-006 stall  in  1  downstream instruction register busy; holds the fetched word.
REQ-007 branch_en  in  1  one-cycle redirect request.
REQ-008 branch_addr  in  ADDR_W  redirect target.
REQ-009 mem_req  out  1  instruction-memory read request.
REQ-010 mem_addr  out  ADDR_W  read address, word-addressed.
REQ-011 mem_rdy  in  1  memory returns valid mem_data this cycle.
REQ-012 mem_data  in  16  instruction word.
REQ-013 ir_d  out  16  fetched instruction; drives the 16-bit instruction register d input.
REQ-014 ir_en  out  1  load strobe for the instruction register en input.
REQ-015 pc_out  out  ADDR_W  address of the word currently on ir_d.
REQ-016 halted  out  1  HALT_OP instruction issued; fetching stopped.

Function
REQ-017 FSM states: IDLE, FETCH, ISSUE, HALT.
REQ-018 IDLE: mem_req=0, ir_en=0; run=1 -> FETCH; mem_rdy ignored.
REQ-019 FETCH: mem_req=1, mem_addr=pc; mem_rdy=1 -> ir_d<=mem_data, pc_out<=pc, -> ISSUE.
REQ-020 ISSUE: mem_req=0; ir_en = !stall && !branch_en (combinational from state and inputs); ir_d and pc_out held stable.
REQ-021 ISSUE with ir_en=1: pc<=pc+1; ir_d[15:12]==HALT_OP -> HALT; else run=1 -> FETCH; else -> IDLE.
REQ-022 ISSUE with stall=1 and branch_en=0: remain in ISSUE; pc unchanged; no new request.
REQ-023 branch_en=1 in FETCH: pc<=branch_addr, outstanding data discarded even if mem_rdy=1 that cycle, remain FETCH; new address on mem_addr the next cycle.
REQ-024 branch_en=1 in ISSUE: held word dropped (ir_en=0), pc<=branch_addr, -> FETCH; branch has priority over stall.
REQ-025 branch_en=1 in IDLE: pc<=branch_addr, stay IDLE unless run=1 (then -> FETCH).
REQ-026 branch_en ignored in HALT.
REQ-027 pc increment modulo 2^ADDR_W: 8'hFF+1 = 8'h00, no flag.
REQ-028 Latency: mem_rdy in cycle N -> ir_en earliest in cycle N+1; peak throughput one instruction per 2 cycles with zero-wait memory.
REQ-029 HALT: halted=1, mem_req=0, ir_en=0; exit only by res.
REQ-030 run=0 during FETCH does not abort the request; evaluated at the issue boundary only.

Reset
REQ-031 res=1 at a rising edge: state<=IDLE, pc<=0, ir_d<=16'h0000, pc_out<=0, halted<=0; overrides every other input that cycle.
REQ-032 Reset mid-FETCH: mem_req=0 in the cycle after the reset edge; a concurrent mem_rdy is discarded.
REQ-033 After reset, mem_req=0 and ir_en=0 until run=1 is sampled.

Structure
REQ-034 Shared package holds the state enumeration (2-bit encoding) and the HALT_OP default constant for use by the decode stage.
REQ-035 One sub-module, pc_counter: ADDR_W register with load (branch), increment, sync reset.
REQ-036 No combinational path from mem_data to ir_d; ir_d is registered.

Verification
REQ-037 Reset, run=1, mem_rdy always 1, mem_data=16'h1234 at addr 0 and 16'h2345 at addr 1 -> ir_en pulses in cycles 2 and 4, ir_d/pc_out = 1234/0 then 2345/1.
REQ-038 stall=1 for 3 cycles in ISSUE -> ir_en low and ir_d stable for 3 cycles, mem_req=0; ir_en=1 on the first cycle after stall drops.
REQ-039 branch_en=1, branch_addr=8'h40 while in ISSUE with stall=1 -> no ir_en; next cycle mem_addr=8'h40.
REQ-040 pc=8'hFF, fetch completes -> next mem_addr=8'h00.
REQ-041 mem_data=16'hF000 issued -> halted=1 the next cycle, mem_req stays 0 with run=1 until res; after res, pc=0 and halted=0.
REQ-042 res=1 in FETCH with mem_rdy=1 -> ir_d stays 16'h0000, no ir_en, state IDLE.
